// File: rtl/riscv_run_ctrl.sv
// Run controller for the RISC-V core behind the AXI4-Lite register block.
// Sequences core reset/enable around a cycle-budgeted run and issues
// instruction-memory write strobes from register-block command ticks.
module riscv_run_ctrl #(
  parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic                       i_run,
  input  logic [31:0]                i_num_cycle,
  input  logic                       i_mem_reset_n,
  input  logic                       i_instruction_write,
  input  logic [31:0]                i_instr_addr,
  input  logic [31:0]                i_instr_data,
  input  logic                       i_core_halt,
  output logic                       o_idle,
  output logic                       o_running,
  output logic                       o_done,
  output logic                       o_core_reset_n,
  output logic                       o_core_en,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]                o_imem_wdata,
  output logic [31:0]                o_cycle_count,
  output logic                       o_halted,
  output logic                       o_wr_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [31:0]                num_q, num_d;
  logic [31:0]                count_q, count_d;
  logic                       halted_q, halted_d;
  logic                       wr_err_q, wr_err_d;
  logic                       prep_q, prep_d;
  logic                       imem_we_q, imem_we_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]                imem_wdata_q, imem_wdata_d;

  logic addr_ok;
  logic wr_accept;
  logic wr_drop;

  // Write address must be word aligned and fall inside the memory.
  assign addr_ok   = (i_instr_addr[1:0] == 2'b00) &&
                     ((i_instr_addr >> (IMEM_ADDR_WIDTH + 2)) == 32'd0);
  assign wr_accept = i_instruction_write && i_mem_reset_n && (state_q == StIdle) && addr_ok;
  // Soft reset suppresses the error flag as well as the write itself.
  assign wr_drop   = i_instruction_write && i_mem_reset_n && !wr_accept;

  // Next-state logic for the run FSM, counters and write path.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    count_d      = count_q;
    halted_d     = halted_q;
    wr_err_d     = wr_err_q;
    prep_d       = prep_q;
    imem_we_d    = wr_accept;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (wr_accept) begin
      imem_addr_d  = i_instr_addr[IMEM_ADDR_WIDTH+1:2];
      imem_wdata_d = i_instr_data;
    end

    if (!i_mem_reset_n) begin
      state_d = StIdle;
      count_d = 32'd0;
      prep_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_run) begin
            num_d    = i_num_cycle;
            count_d  = 32'd0;
            halted_d = 1'b0;
            wr_err_d = 1'b0;
            prep_d   = 1'b0;
            state_d  = (i_num_cycle == 32'd0) ? StDone : StPrep;
          end
        end
        StPrep: begin
          if (prep_q) begin
            state_d = StRun;
          end else begin
            prep_d = 1'b1;
          end
        end
        StRun: begin
          count_d = count_q + 32'd1;
          // Exit compare fires at N, so the counter never wraps.
          if ((count_d == num_q) || i_core_halt) begin
            state_d = StDone;
          end
          if (i_core_halt) begin
            halted_d = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
      endcase
    end

    // A dropped write in the same cycle as a run start still reports.
    if (wr_drop) begin
      wr_err_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= StIdle;
      num_q        <= 32'd0;
      count_q      <= 32'd0;
      halted_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      prep_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      wr_err_q     <= wr_err_d;
      prep_q       <= prep_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign o_idle         = (state_q == StIdle);
  assign o_running      = (state_q == StPrep) || (state_q == StRun);
  assign o_done         = (state_q == StDone);
  assign o_core_reset_n = (state_q == StRun);
  assign o_core_en      = (state_q == StRun);
  assign o_imem_we      = imem_we_q;
  assign o_imem_addr    = imem_addr_q;
  assign o_imem_wdata   = imem_wdata_q;
  assign o_cycle_count  = count_q;
  assign o_halted       = halted_q;
  assign o_wr_err       = wr_err_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed and randomized runs/writes checked
// against a timeline model derived from the run length and halt point.
module tb_riscv_run_ctrl;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_run, i_mem_reset_n, i_instruction_write, i_core_halt;
  logic [31:0]   i_num_cycle, i_instr_addr, i_instr_data;
  logic          o_idle, o_running, o_done, o_core_reset_n, o_core_en;
  logic          o_imem_we, o_halted, o_wr_err;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata, o_cycle_count;

  int   checks = 0;
  int   errors = 0;
  logic exp_err;

  riscv_run_ctrl #(.IMEM_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK         (clk),
    .S_AXI_ARESETN      (rst_n),
    .i_run              (i_run),
    .i_num_cycle        (i_num_cycle),
    .i_mem_reset_n      (i_mem_reset_n),
    .i_instruction_write(i_instruction_write),
    .i_instr_addr       (i_instr_addr),
    .i_instr_data       (i_instr_data),
    .i_core_halt        (i_core_halt),
    .o_idle             (o_idle),
    .o_running          (o_running),
    .o_done             (o_done),
    .o_core_reset_n     (o_core_reset_n),
    .o_core_en          (o_core_en),
    .o_imem_we          (o_imem_we),
    .o_imem_addr        (o_imem_addr),
    .o_imem_wdata       (o_imem_wdata),
    .o_cycle_count      (o_cycle_count),
    .o_halted           (o_halted),
    .o_wr_err           (o_wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_idle"}, o_idle, 1'b1);
    chk1({tag, "_running"}, o_running, 1'b0);
    chk1({tag, "_done"}, o_done, 1'b0);
    chk1({tag, "_core_reset_n"}, o_core_reset_n, 1'b0);
    chk1({tag, "_core_en"}, o_core_en, 1'b0);
    chk1({tag, "_imem_we"}, o_imem_we, 1'b0);
    chk32({tag, "_imem_addr"}, 32'(o_imem_addr), 32'd0);
    chk32({tag, "_imem_wdata"}, o_imem_wdata, 32'd0);
    chk32({tag, "_cycle_count"}, o_cycle_count, 32'd0);
    chk1({tag, "_halted"}, o_halted, 1'b0);
    chk1({tag, "_wr_err"}, o_wr_err, 1'b0);
  endtask

  // Issue one write tick from a negedge while idle; ends on a negedge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = (a % 4 == 0) && (a < 4 * (32'd1 << AW));
    i_instruction_write = 1'b1;
    i_instr_addr        = a;
    i_instr_data        = d;
    @(negedge clk);
    i_instruction_write = 1'b0;
    if (!ok) exp_err = 1'b1;
    chk1("wr_we", o_imem_we, ok);
    if (ok) begin
      chk32("wr_addr", 32'(o_imem_addr), a / 4);
      chk32("wr_data", o_imem_wdata, d);
    end
    chk1("wr_err", o_wr_err, exp_err);
    @(negedge clk);
    chk1("wr_we_one_cycle", o_imem_we, 1'b0);
  endtask

  // One run of budget n; halt_k>0 pulses halt in RUN cycle halt_k.
  // Cycle j counts from the first clock after i_run is sampled.
  task automatic run_seq(input logic [31:0] n, input int halt_k, input bit noise);
    int   e;
    int   last;
    logic x_run, x_en, x_done, x_idle;
    int   x_cnt;
    e    = (halt_k != 0) ? halt_k : int'(n);
    last = (n == 0) ? 2 : e + 4;
    i_run       = 1'b1;
    i_num_cycle = n;
    exp_err     = 1'b0;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      i_run               = 1'b0;
      i_core_halt         = 1'b0;
      i_instruction_write = 1'b0;
      if (n == 0) begin
        x_run  = 1'b0;
        x_en   = 1'b0;
        x_done = (j == 1);
        x_idle = (j == 2);
        x_cnt  = 0;
      end else begin
        x_run  = (j <= e + 2);
        x_en   = (j >= 3) && (j <= e + 2);
        x_done = (j == e + 3);
        x_idle = (j == e + 4);
        x_cnt  = (j < 3) ? 0 : ((j - 3 < e) ? j - 3 : e);
      end
      chk1("run_running", o_running, x_run);
      chk1("run_core_en", o_core_en, x_en);
      chk1("run_core_reset_n", o_core_reset_n, x_en);
      chk1("run_done", o_done, x_done);
      chk1("run_idle", o_idle, x_idle);
      chk1("run_imem_we", o_imem_we, 1'b0);
      chk32("run_cycle_count", o_cycle_count, 32'(x_cnt));
      if (x_done) chk1("run_halted", o_halted, halt_k != 0);
      if (n != 0 && halt_k != 0 && j == halt_k + 2) i_core_halt = 1'b1;
      if (noise && n != 0 && j <= e + 2) begin
        if ($urandom_range(0, 3) == 0) begin
          i_run       = 1'b1;
          i_num_cycle = $urandom;
        end
        if ($urandom_range(0, 3) == 0) begin
          i_instruction_write = 1'b1;
          i_instr_addr        = 32'($urandom_range(0, 1023)) * 4;
          i_instr_data        = $urandom;
          exp_err             = 1'b1;
        end
      end
    end
    chk1("run_wr_err", o_wr_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] n;
    int          k;
    logic [31:0] a;
    int          budget;

    rst_n = 1'b1;
    i_run = 1'b0;
    i_num_cycle = 32'd0;
    i_mem_reset_n = 1'b1;
    i_instruction_write = 1'b0;
    i_instr_addr = 32'd0;
    i_instr_data = 32'd0;
    i_core_halt = 1'b0;
    exp_err = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_write(32'h0, 32'h0000_0013);
    do_write(32'h4, 32'h0010_0093);
    do_write(32'h8, 32'h0000_0073);
    chk1("load_no_err", o_wr_err, 1'b0);

    run_seq(32'd5, 0, 1'b0);
    run_seq(32'd100, 10, 1'b0);

    do_write(32'h2, 32'hDEAD_BEEF);
    do_write(32'h1000, 32'hCAFE_F00D);
    chk1("bad_wr_sticky", o_wr_err, 1'b1);
    run_seq(32'd0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = 32'($urandom_range(1, 20));
      k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
      run_seq(n, k, 1'b1);
    end

    for (int r = 0; r < 10; r++) begin
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1023)) * 4 : $urandom;
      do_write(a, $urandom);
    end

    // Run and write in the same idle cycle: both take effect.
    i_run = 1'b1;
    i_num_cycle = 32'd3;
    i_instruction_write = 1'b1;
    i_instr_addr = 32'h10;
    i_instr_data = 32'h1234_5678;
    @(negedge clk);
    i_run = 1'b0;
    i_instruction_write = 1'b0;
    chk1("both_we", o_imem_we, 1'b1);
    chk32("both_addr", 32'(o_imem_addr), 32'd4);
    chk32("both_data", o_imem_wdata, 32'h1234_5678);
    chk1("both_running", o_running, 1'b1);
    chk1("both_core_reset_n", o_core_reset_n, 1'b0);
    budget = 0;
    while (!o_idle && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk1("both_back_idle", o_idle, 1'b1);
    chk32("both_count", o_cycle_count, 32'd3);
    exp_err = 1'b0;

    // Soft reset at RUN cycle 20 of a 50-cycle run.
    i_run = 1'b1;
    i_num_cycle = 32'd50;
    repeat (22) begin
      @(negedge clk);
      i_run = 1'b0;
    end
    chk1("mr_in_run", o_core_en, 1'b1);
    chk32("mr_count_before", o_cycle_count, 32'd19);
    i_mem_reset_n = 1'b0;
    i_run = 1'b1;
    i_num_cycle = 32'd4;
    i_instruction_write = 1'b1;
    i_instr_addr = 32'h3;
    @(negedge clk);
    chk1("mr_idle", o_idle, 1'b1);
    chk1("mr_core_en", o_core_en, 1'b0);
    chk1("mr_core_reset_n", o_core_reset_n, 1'b0);
    chk1("mr_done", o_done, 1'b0);
    chk32("mr_count", o_cycle_count, 32'd0);
    i_instr_addr = 32'h20;
    @(negedge clk);
    chk1("mr_no_err", o_wr_err, 1'b0);
    chk1("mr_run_ignored", o_idle, 1'b1);
    chk1("mr_wr_ignored", o_imem_we, 1'b0);
    i_mem_reset_n = 1'b1;
    i_run = 1'b0;
    i_instruction_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("mr_after_done", o_done, 1'b0);
      chk1("mr_after_idle", o_idle, 1'b1);
    end

    // Hard asynchronous reset in the middle of a run.
    i_run = 1'b1;
    i_num_cycle = 32'hFFFF_FFFF;
    repeat (10) begin
      @(negedge clk);
      i_run = 1'b0;
    end
    chk1("ar_in_run", o_core_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("ar_stays_idle", o_idle, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
